// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS-subset control FSM with memory handshakes
// and free-running cycle / retired-instruction counters.
module mc_ctrl_hs #(
  parameter int CNT_W = 32,
  parameter bit HS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic             zf,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pc_wr,
  output logic [4:0]       lat_en,
  output logic             dm_wr,
  output logic             rf_wr,
  output logic             ext_sz,
  output logic             alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       rf_w_sel,
  output logic [1:0]       rf_din_sel,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MCALC  = 4'd2;
  localparam logic [3:0] S_MLOAD  = 4'd3;
  localparam logic [3:0] S_MSTORE = 4'd4;
  localparam logic [3:0] S_MLDFIN = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RFIN   = 4'd7;
  localparam logic [3:0] S_IEXEC  = 4'd8;
  localparam logic [3:0] S_IFIN   = 4'd9;
  localparam logic [3:0] S_BRFIN  = 4'd10;
  localparam logic [3:0] S_JFIN   = 4'd11;
  localparam logic [3:0] S_JRFIN  = 4'd12;
  localparam logic [3:0] S_ILL    = 4'd13;

  localparam logic [3:0] OP_ADDU  = 4'd0;
  localparam logic [3:0] OP_SUBU  = 4'd1;
  localparam logic [3:0] OP_ORI   = 4'd2;
  localparam logic [3:0] OP_LW    = 4'd3;
  localparam logic [3:0] OP_SW    = 4'd4;
  localparam logic [3:0] OP_BEQ   = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_BNE   = 4'd7;
  localparam logic [3:0] OP_ADDIU = 4'd8;
  localparam logic [3:0] OP_LUI   = 4'd9;
  localparam logic [3:0] OP_SLT   = 4'd10;
  localparam logic [3:0] OP_J     = 4'd11;
  localparam logic [3:0] OP_JR    = 4'd12;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_LUI = 3'd4;

  logic [3:0]       r_state;
  logic [3:0]       w_next;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ins;
  logic             w_iack;
  logic             w_dack;
  logic             w_retire;

  assign w_iack = HS_EN ? imem_ack : 1'b1;
  assign w_dack = HS_EN ? dmem_ack : 1'b1;

  always_comb begin
    w_next     = S_FETCH;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    pc_wr      = 1'b0;
    lat_en     = 5'b00000;
    dm_wr      = 1'b0;
    rf_wr      = 1'b0;
    ext_sz     = 1'b1;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 2'd0;
    alu_ctrl   = ALU_ADD;
    rf_w_sel   = 2'd0;
    rf_din_sel = 2'd0;
    pc_sel     = 2'd0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req  = 1'b1;
        pc_sel    = 2'd1;
        pc_wr     = w_iack;
        lat_en[4] = w_iack;
        w_next    = w_iack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        lat_en    = 5'b01001;
        alu_b_sel = 2'd2;
        unique case (1'b1)
          (op == OP_ADDU) || (op == OP_SUBU) || (op == OP_SLT):
            w_next = S_REXEC;
          (op == OP_LW) || (op == OP_SW):
            w_next = S_MCALC;
          (op == OP_ORI) || (op == OP_ADDIU) || (op == OP_LUI):
            w_next = S_IEXEC;
          (op == OP_BEQ) || (op == OP_BNE):
            w_next = S_BRFIN;
          (op == OP_JAL) || (op == OP_J):
            w_next = S_JFIN;
          (op == OP_JR):
            w_next = S_JRFIN;
          default:
            w_next = S_ILL;
        endcase
      end
      S_REXEC: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 2'd1;
        lat_en[2] = 1'b1;
        alu_ctrl  = (op == OP_SUBU) ? ALU_SUB :
                    (op == OP_SLT)  ? ALU_SLT : ALU_ADD;
        w_next    = S_RFIN;
      end
      S_RFIN: begin
        rf_wr      = 1'b1;
        rf_w_sel   = 2'd1;
        rf_din_sel = 2'd1;
      end
      S_IEXEC: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 2'd3;
        lat_en[2] = 1'b1;
        ext_sz    = (op != OP_ORI);
        alu_ctrl  = (op == OP_ORI) ? ALU_OR  :
                    (op == OP_LUI) ? ALU_LUI : ALU_ADD;
        w_next    = S_IFIN;
      end
      S_IFIN: begin
        rf_wr      = 1'b1;
        rf_din_sel = 2'd1;
      end
      S_MCALC: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 2'd3;
        lat_en[2] = 1'b1;
        w_next    = (op == OP_LW) ? S_MLOAD : S_MSTORE;
      end
      S_MLOAD: begin
        dmem_req  = 1'b1;
        lat_en[1] = w_dack;
        w_next    = w_dack ? S_MLDFIN : S_MLOAD;
      end
      S_MLDFIN: begin
        rf_wr = 1'b1;
      end
      S_MSTORE: begin
        dmem_req = 1'b1;
        dm_wr    = 1'b1;
        w_next   = w_dack ? S_FETCH : S_MSTORE;
      end
      S_BRFIN: begin
        alu_a_sel = 1'b1;
        alu_b_sel = 2'd1;
        alu_ctrl  = ALU_SUB;
        pc_wr     = ((op == OP_BEQ) & zf) | ((op == OP_BNE) & ~zf);
      end
      S_JFIN: begin
        pc_sel = 2'd2;
        pc_wr  = 1'b1;
        if (op == OP_JAL) begin
          rf_wr      = 1'b1;
          rf_w_sel   = 2'd2;
          rf_din_sel = 2'd2;
        end
      end
      S_JRFIN: begin
        pc_sel = 2'd3;
        pc_wr  = 1'b1;
      end
      S_ILL: begin
        illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // reset must silence every strobe, even FETCH's request
    if (!rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      pc_wr    = 1'b0;
      lat_en   = 5'b00000;
      dm_wr    = 1'b0;
      rf_wr    = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign w_retire = (w_next == S_FETCH) &&
                    (r_state != S_FETCH) &&
                    (r_state < S_ILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_cyc   <= '0;
      r_ins   <= '0;
    end else begin
      r_state <= w_next;
      r_cyc   <= r_cyc + CNT_W'(1);
      if (w_retire)
        r_ins <= r_ins + CNT_W'(1);
    end
  end

  assign state       = r_state;
  assign cycle_cnt   = r_cyc;
  assign instret_cnt = r_ins;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed cycle-trace bench for mc_ctrl_hs (CNT_W=4, HS_EN=1).
// Table rows are one clock each; hand sequences cover reset and wrap.
module tb_mc_ctrl_hs;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] op;
  logic       zf, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, pc_wr, dm_wr, rf_wr;
  logic [4:0] lat_en;
  logic       ext_sz, alu_a_sel, illegal;
  logic [1:0] alu_b_sel, rf_w_sel, rf_din_sel, pc_sel;
  logic [2:0] alu_ctrl;
  logic [3:0] state, cycle_cnt, instret_cnt;

  int n_chk = 0;
  int n_fail = 0;

  mc_ctrl_hs #(.CNT_W(4), .HS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .zf(zf),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req),
    .pc_wr(pc_wr), .lat_en(lat_en), .dm_wr(dm_wr),
    .rf_wr(rf_wr), .ext_sz(ext_sz),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_ctrl(alu_ctrl), .rf_w_sel(rf_w_sel),
    .rf_din_sel(rf_din_sel), .pc_sel(pc_sel),
    .illegal(illegal), .state(state),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  // {imem_req, dmem_req, pc_wr, lat_en, dm_wr, rf_wr, illegal}
  localparam logic [10:0] F0   = 11'b1_0_0_00000_0_0_0;
  localparam logic [10:0] F1   = 11'b1_0_1_10000_0_0_0;
  localparam logic [10:0] DEC  = 11'b0_0_0_01001_0_0_0;
  localparam logic [10:0] EXE  = 11'b0_0_0_00100_0_0_0;
  localparam logic [10:0] WB   = 11'b0_0_0_00000_0_1_0;
  localparam logic [10:0] MST  = 11'b0_1_0_00000_1_0_0;
  localparam logic [10:0] NONE = 11'b0_0_0_00000_0_0_0;
  localparam logic [10:0] PCW  = 11'b0_0_1_00000_0_0_0;
  localparam logic [10:0] JAL  = 11'b0_0_1_00000_0_1_0;
  localparam logic [10:0] ILLP = 11'b0_0_0_00000_0_0_1;
  localparam logic [10:0] ML0  = 11'b0_1_0_00000_0_0_0;
  localparam logic [10:0] ML1  = 11'b0_1_0_00010_0_0_0;

  typedef struct {
    logic [3:0]  op;
    logic        zf, ia, da;
    logic [3:0]  st;
    logic [10:0] stb;
    logic [1:0]  pcs;
    logic [2:0]  alu;
    logic        ca;
    logic [1:0]  ws, ds;
    logic [3:0]  ic;
  } vec_t;

  vec_t tv[40];

  function automatic vec_t mk(
    input logic [3:0] o, input logic z, input logic ia, input logic da,
    input logic [3:0] st, input logic [10:0] stb, input logic [1:0] pcs,
    input logic [2:0] alu, input logic ca, input logic [1:0] ws,
    input logic [1:0] ds, input logic [3:0] ic);
    vec_t v;
    v.op = o; v.zf = z; v.ia = ia; v.da = da; v.st = st; v.stb = stb;
    v.pcs = pcs; v.alu = alu; v.ca = ca; v.ws = ws; v.ds = ds; v.ic = ic;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] strobes();
    return {imem_req, dmem_req, pc_wr, lat_en, dm_wr, rf_wr, illegal};
  endfunction

  initial begin
    // addu, imem_ack held off for 3 cycles
    tv[0]  = mk(0, 0, 0, 0, 0,  F0,   1, 0, 1, 0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0,  F0,   1, 0, 1, 0, 0, 0);
    tv[2]  = mk(0, 0, 0, 0, 0,  F0,   1, 0, 1, 0, 0, 0);
    tv[3]  = mk(0, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 0);
    tv[4]  = mk(0, 0, 1, 0, 1,  DEC,  0, 0, 1, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, 0, 6,  EXE,  0, 0, 1, 0, 0, 0);
    tv[6]  = mk(0, 0, 0, 0, 7,  WB,   0, 0, 0, 1, 1, 0);
    // sw, dmem_ack after 2 wait cycles
    tv[7]  = mk(4, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 1);
    tv[8]  = mk(4, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 1);
    tv[9]  = mk(4, 0, 0, 0, 2,  EXE,  0, 0, 1, 0, 0, 1);
    tv[10] = mk(4, 0, 0, 0, 4,  MST,  0, 0, 0, 0, 0, 1);
    tv[11] = mk(4, 0, 0, 0, 4,  MST,  0, 0, 0, 0, 0, 1);
    tv[12] = mk(4, 0, 0, 1, 4,  MST,  0, 0, 0, 0, 0, 1);
    // beq zf=0 then bne zf=0
    tv[13] = mk(5, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 2);
    tv[14] = mk(5, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 2);
    tv[15] = mk(5, 0, 0, 0, 10, NONE, 0, 1, 1, 0, 0, 2);
    tv[16] = mk(7, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 3);
    tv[17] = mk(7, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 3);
    tv[18] = mk(7, 0, 0, 0, 10, PCW,  0, 1, 1, 0, 0, 3);
    // illegal op 14: no retire
    tv[19] = mk(14, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 4);
    tv[20] = mk(14, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 4);
    tv[21] = mk(14, 0, 0, 0, 13, ILLP, 0, 0, 0, 0, 0, 4);
    // lw with stray dmem_ack in FETCH, one wait cycle
    tv[22] = mk(3, 0, 1, 1, 0,  F1,   1, 0, 1, 0, 0, 4);
    tv[23] = mk(3, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 4);
    tv[24] = mk(3, 0, 0, 0, 2,  EXE,  0, 0, 1, 0, 0, 4);
    tv[25] = mk(3, 0, 0, 0, 3,  ML0,  0, 0, 0, 0, 0, 4);
    tv[26] = mk(3, 0, 0, 1, 3,  ML1,  0, 0, 0, 0, 0, 4);
    tv[27] = mk(3, 0, 0, 0, 5,  WB,   0, 0, 0, 0, 0, 4);
    // jal, addiu, jr
    tv[28] = mk(6, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 5);
    tv[29] = mk(6, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 5);
    tv[30] = mk(6, 0, 0, 0, 11, JAL,  2, 0, 0, 2, 2, 5);
    tv[31] = mk(8, 0, 1, 0, 0,  F1,   1, 0, 1, 0, 0, 6);
    tv[32] = mk(8, 0, 0, 0, 1,  DEC,  0, 0, 1, 0, 0, 6);
    tv[33] = mk(8, 0, 0, 0, 8,  EXE,  0, 0, 1, 0, 0, 6);
    tv[34] = mk(8, 0, 0, 0, 9,  WB,   0, 0, 0, 0, 1, 6);
    tv[35] = mk(12, 0, 1, 0, 0,  F1,  1, 0, 1, 0, 0, 7);
    tv[36] = mk(12, 0, 0, 0, 1,  DEC, 0, 0, 1, 0, 0, 7);
    tv[37] = mk(12, 0, 0, 0, 12, PCW, 3, 0, 0, 0, 0, 7);
    tv[38] = mk(0, 0, 0, 1, 0,  F0,   1, 0, 1, 0, 0, 8);
    tv[39] = mk(0, 0, 0, 0, 0,  F0,   1, 0, 1, 0, 0, 8);

    rst = 1'b1; op = 4'd0; zf = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_cnts", {24'd0, cycle_cnt, instret_cnt}, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      op = tv[i].op; zf = tv[i].zf;
      imem_ack = tv[i].ia; dmem_ack = tv[i].da;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state), 32'(tv[i].st));
      chk($sformatf("row%0d_strobes", i), 32'(strobes()), 32'(tv[i].stb));
      chk($sformatf("row%0d_instret", i), 32'(instret_cnt), 32'(tv[i].ic));
      if (tv[i].ca)
        chk($sformatf("row%0d_alu", i), 32'(alu_ctrl), 32'(tv[i].alu));
      if (tv[i].stb[8])
        chk($sformatf("row%0d_pcsel", i), 32'(pc_sel), 32'(tv[i].pcs));
      if (tv[i].stb[1])
        chk($sformatf("row%0d_rfsel", i), {28'd0, rf_w_sel, rf_din_sel},
            {28'd0, tv[i].ws, tv[i].ds});
    end

    // async reset in the middle of a load wait
    @(negedge clk);
    op = 4'd3; imem_ack = 1'b1; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    #1 chk("mload_reached", 32'(state), 32'd3);
    chk("mload_req", 32'(dmem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_cnts", {24'd0, cycle_cnt, instret_cnt}, 32'd0);
    chk("async_strobes", 32'(strobes()), 32'd0);
    @(negedge clk);
    chk("held_state", 32'(state), 32'd0);
    chk("held_cyc", 32'(cycle_cnt), 32'd0);
    rst = 1'b1;
    #1 chk("resume_req", 32'(imem_req), 32'd1);

    // 17 clocks on a 4-bit counter wraps to 1
    repeat (17) @(negedge clk);
    #1;
    chk("wrap_cyc", 32'(cycle_cnt), 32'd1);
    chk("wrap_state", 32'(state), 32'd0);
    chk("wrap_instret", 32'(instret_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
